mem_stage: RTL and testbench

//  MEM stage of the 5-stage MIPS pipeline: directly downstream of EX, consuming the EX/MEM outputs (alu_result,

---
 rtl/mem_pkg.sv | 53 +++++
 rtl/data_mem.sv | 28 ++
 rtl/mem_stage.sv | 93 +++++++++
 tb/tb_mem_stage.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// MEM stage shared encodings and lane helpers: access-size codes, alignment test,
// byte-enable and store-lane replication, load lane extraction with sign/zero extend.
package mem_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b11;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_SIZE_BYTE: misaligned = 1'b0;
      MEM_SIZE_HALF: misaligned = off[0];
      default:       misaligned = (off != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_SIZE_BYTE: byte_en = 4'b0001 << off;
      MEM_SIZE_HALF: byte_en = off[1] ? 4'b1100 : 4'b0011;
      default:       byte_en = 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across every lane so the byte enables alone pick the target.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      MEM_SIZE_BYTE: store_lanes = {4{wd[7:0]}};
      MEM_SIZE_HALF: store_lanes = {2{wd[15:0]}};
      default:       store_lanes = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [31:0] sh;
    case (size)
      MEM_SIZE_BYTE: begin
        sh = word >> {off, 3'b000};
        load_extend = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      MEM_SIZE_HALF: begin
        sh = word >> {off[1], 4'b0000};
        load_extend = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      default: begin
        sh = word;
        load_extend = sh;
      end
    endcase
  endfunction

endpackage

// File: rtl/data_mem.sv
// Data memory: MEM_DEPTH x 32 array, byte-enable write on the rising edge, async read
// and debug ports. No reset of contents; reads see only writes from earlier edges.
module data_mem #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata    = mem[addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: aligned byte/half/word load-store on data_mem, MEM/WB latch one cycle
// after EX/MEM inputs. No backpressure; i_halt freezes the latch and blocks stores.
module mem_stage
  import mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_halt,
  input  logic [DATA_W-1:0] i_ex_m_alu_result,
  input  logic [DATA_W-1:0] i_ex_m_write_data,
  input  logic [4:0]        i_ex_m_rd,
  input  logic              i_ex_m_mem_read,
  input  logic              i_ex_m_mem_write,
  input  logic              i_ex_m_mem_to_reg,
  input  logic              i_ex_m_reg_write,
  input  logic [1:0]        i_ex_m_mem_size,
  input  logic              i_ex_m_mem_unsigned,
  input  logic [ADDR_W-1:0] i_du_mem_addr,
  output logic [DATA_W-1:0] o_du_mem_data,
  output logic [DATA_W-1:0] o_m_wb_read_data,
  output logic [DATA_W-1:0] o_m_wb_alu_result,
  output logic [DATA_W-1:0] o_m_wb_data_write,
  output logic [4:0]        o_m_wb_rd,
  output logic              o_m_wb_mem_to_reg,
  output logic              o_m_wb_reg_write,
  output logic              o_addr_error
);

  logic [1:0]        off;
  logic [ADDR_W-1:0] word_idx;
  logic              misal;
  logic [3:0]        be;
  logic [DATA_W-1:0] wlanes;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] wb_value;
  logic              reg_write_q;
  logic              unused_addr_hi;

  assign off            = i_ex_m_alu_result[1:0];
  assign word_idx       = i_ex_m_alu_result[ADDR_W+1:2];
  assign unused_addr_hi = ^i_ex_m_alu_result[DATA_W-1:ADDR_W+2];

  assign misal  = (i_ex_m_mem_read | i_ex_m_mem_write) & misaligned(i_ex_m_mem_size, off);
  // Gating with i_reset drops a store that meets an edge while reset is held.
  assign be     = (i_ex_m_mem_write && !i_halt && !misal && i_reset)
                  ? byte_en(i_ex_m_mem_size, off) : 4'b0000;
  assign wlanes = store_lanes(i_ex_m_mem_size, i_ex_m_write_data);

  data_mem #(
    .DATA_W   (DATA_W),
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_W   (ADDR_W)
  ) u_data_mem (
    .clk     (i_clk),
    .be      (be),
    .addr    (word_idx),
    .wdata   (wlanes),
    .rdata   (rd_word),
    .dbg_addr(i_du_mem_addr),
    .dbg_data(o_du_mem_data)
  );

  assign load_data   = (i_ex_m_mem_read && misal) ? '0
                       : load_extend(rd_word, i_ex_m_mem_size, off, i_ex_m_mem_unsigned);
  assign wb_value    = i_ex_m_mem_to_reg ? load_data : i_ex_m_alu_result;
  assign reg_write_q = i_ex_m_reg_write & ~(i_ex_m_mem_read & misal);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_m_wb_read_data  <= '0;
      o_m_wb_alu_result <= '0;
      o_m_wb_data_write <= '0;
      o_m_wb_rd         <= '0;
      o_m_wb_mem_to_reg <= 1'b0;
      o_m_wb_reg_write  <= 1'b0;
      o_addr_error      <= 1'b0;
    end else if (!i_halt) begin
      o_m_wb_read_data  <= load_data;
      o_m_wb_alu_result <= i_ex_m_alu_result;
      o_m_wb_data_write <= wb_value;
      o_m_wb_rd         <= i_ex_m_rd;
      o_m_wb_mem_to_reg <= i_ex_m_mem_to_reg;
      o_m_wb_reg_write  <= reg_write_q;
      o_addr_error      <= o_addr_error | misal;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected MEM/WB contents queued at issue, popped and
// compared one edge later; debug-port and reset checks compared directly.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic [31:0] alu, wd;
  logic [4:0]  rd;
  logic        mr, mw, m2r, rw, uns;
  logic [1:0]  sz;
  logic [7:0]  du_addr;
  logic [31:0] du_data, o_rdata, o_alu, o_dw;
  logic [4:0]  o_rd;
  logic        o_m2r, o_rw, o_aerr;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        chk_rdata;
    logic [31:0] alu;
    logic [31:0] dw;
    logic [4:0]  rd;
    logic        m2r;
    logic        rw;
    logic        aerr;
  } exp_t;

  exp_t q[$];
  exp_t last;

  always #5 clk = ~clk;

  mem_stage dut (
    .i_clk              (clk),
    .i_reset            (rst_n),
    .i_halt             (halt),
    .i_ex_m_alu_result  (alu),
    .i_ex_m_write_data  (wd),
    .i_ex_m_rd          (rd),
    .i_ex_m_mem_read    (mr),
    .i_ex_m_mem_write   (mw),
    .i_ex_m_mem_to_reg  (m2r),
    .i_ex_m_reg_write   (rw),
    .i_ex_m_mem_size    (sz),
    .i_ex_m_mem_unsigned(uns),
    .i_du_mem_addr      (du_addr),
    .o_du_mem_data      (du_data),
    .o_m_wb_read_data   (o_rdata),
    .o_m_wb_alu_result  (o_alu),
    .o_m_wb_data_write  (o_dw),
    .o_m_wb_rd          (o_rd),
    .o_m_wb_mem_to_reg  (o_m2r),
    .o_m_wb_reg_write   (o_rw),
    .o_addr_error       (o_aerr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] w, input logic [4:0] r,
                       input logic rd_en, input logic wr_en, input logic to_reg, input logic regw,
                       input logic [1:0] size, input logic u, input logic h,
                       input logic [31:0] rdata_exp, input logic chk_r);
    exp_t e;
    logic mis;
    alu = a; wd = w; rd = r; mr = rd_en; mw = wr_en; m2r = to_reg; rw = regw;
    sz = size; uns = u; halt = h;
    mis = (size == 2'b01 && a[0]) || (size[1] && a[1:0] != 2'b00);
    if (h) begin
      e = last;
    end else begin
      e.rdata     = rdata_exp;
      e.chk_rdata = chk_r;
      e.alu       = a;
      e.dw        = to_reg ? rdata_exp : a;
      e.rd        = r;
      e.m2r       = to_reg;
      e.rw        = regw & ~(rd_en & mis);
      e.aerr      = last.aerr | ((rd_en | wr_en) & mis);
    end
    q.push_back(e);
    last = e;
  endtask

  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      if (e.chk_rdata) chk({tag, "_rdata"}, o_rdata, e.rdata);
      chk({tag, "_alu"}, o_alu, e.alu);
      chk({tag, "_dw"}, o_dw, e.dw);
      chk({tag, "_rd"}, {27'd0, o_rd}, {27'd0, e.rd});
      chk({tag, "_ctl"}, {29'd0, o_m2r, o_rw, o_aerr}, {29'd0, e.m2r, e.rw, e.aerr});
    end
  endtask

  task automatic idle();
    alu = '0; wd = '0; rd = '0; mr = 0; mw = 0; m2r = 0; rw = 0; sz = 2'b11; uns = 0; halt = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    du_addr = '0;
    idle();
    last = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", o_dw | o_alu | o_rdata, 32'd0);
    chk("reset_ctl", {27'd0, o_rd} | {29'd0, o_m2r, o_rw, o_aerr}, 32'd0);
    rst_n = 1'b1;

    // 1: sw / lw
    issue(32'h10, 32'hDEADBEEF, 5'd0, 0, 1, 0, 0, 2'b11, 0, 0, 32'h0, 0); step("sw10");
    issue(32'h10, 32'h0, 5'd9, 1, 0, 1, 1, 2'b11, 0, 0, 32'hDEADBEEF, 1); step("lw10");

    // 2: byte store into zeroed word, signed/unsigned byte loads
    issue(32'h20, 32'h0, 5'd0, 0, 1, 0, 0, 2'b11, 0, 0, 32'h0, 0); step("sw20");
    issue(32'h21, 32'h80, 5'd0, 0, 1, 0, 0, 2'b00, 0, 0, 32'h0, 0); step("sb21");
    issue(32'h21, 32'h0, 5'd4, 1, 0, 1, 1, 2'b00, 0, 0, 32'hFFFFFF80, 1); step("lb21");
    issue(32'h21, 32'h0, 5'd5, 1, 0, 1, 1, 2'b00, 1, 0, 32'h00000080, 1); step("lbu21");
    du_addr = 8'd8; #1;
    chk("du_w8", du_data, 32'h00008000);

    // 3: halfword stores and loads
    issue(32'h32, 32'hAAAA1234, 5'd0, 0, 1, 0, 0, 2'b01, 0, 0, 32'h0, 0); step("sh32");
    issue(32'h30, 32'h00008001, 5'd0, 0, 1, 0, 0, 2'b01, 0, 0, 32'h0, 0); step("sh30");
    issue(32'h32, 32'h0, 5'd6, 1, 0, 1, 1, 2'b01, 1, 0, 32'h00001234, 1); step("lhu32");
    issue(32'h30, 32'h0, 5'd7, 1, 0, 1, 1, 2'b01, 0, 0, 32'hFFFF8001, 1); step("lh30");
    issue(32'h30, 32'h0, 5'd8, 1, 0, 1, 1, 2'b11, 0, 0, 32'h12348001, 1); step("lw30");
    // read+write together: store lands, load sees the pre-write word
    issue(32'h30, 32'h55, 5'd3, 1, 1, 1, 1, 2'b11, 0, 0, 32'h12348001, 1); step("rw30");
    du_addr = 8'd12; #1;
    chk("du_w12", du_data, 32'h00000055);

    // 4: misaligned load and store
    issue(32'h13, 32'h0, 5'd2, 1, 0, 1, 1, 2'b11, 0, 0, 32'h0, 1); step("lw13_mis");
    issue(32'h12, 32'h11111111, 5'd0, 0, 1, 0, 0, 2'b11, 0, 0, 32'h0, 0); step("sw12_mis");
    du_addr = 8'd4; #1;
    chk("du_w4_unchanged", du_data, 32'hDEADBEEF);
    issue(32'h14, 32'h0, 5'd0, 0, 0, 0, 0, 2'b11, 0, 0, 32'h0, 0); step("aerr_sticky");

    // 5: ALU passthrough then halt
    issue(32'h40, 32'h0, 5'd0, 0, 1, 0, 0, 2'b11, 0, 0, 32'h0, 0); step("sw40");
    issue(32'h5, 32'h0, 5'd9, 0, 0, 0, 1, 2'b11, 0, 0, 32'h0, 0); step("alu5");
    issue(32'h40, 32'hCAFEF00D, 5'd1, 0, 1, 0, 0, 2'b11, 0, 1, 32'h0, 0); step("halt_sw");
    issue(32'h13, 32'h0, 5'd1, 1, 0, 1, 1, 2'b11, 0, 1, 32'h0, 0); step("halt_hold");
    du_addr = 8'd16; #1;
    chk("du_w16_halt", du_data, 32'h0);
    idle();

    // 6: async reset between edges with an in-flight store
    issue(32'h10, 32'h77777777, 5'd3, 0, 1, 0, 1, 2'b11, 0, 0, 32'h0, 0); step("sw10_pre");
    alu = 32'h10; wd = 32'h99999999; mw = 1; rw = 1; rd = 5'd3;
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", o_dw | o_alu | o_rdata, 32'd0);
    chk("async_rst_ctl", {27'd0, o_rd} | {29'd0, o_m2r, o_rw, o_aerr}, 32'd0);
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;
    last = '0;
    du_addr = 8'd4; #1;
    chk("du_w4_after_rst", du_data, 32'h77777777);
    issue(32'h3C, 32'h0, 5'd1, 0, 0, 0, 1, 2'b11, 0, 0, 32'h0, 0); step("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
